sig_lut_loader: RTL and testbench

SIG_LUT_LOADER -- requirements
Module: sig_lut_loader

---
 rtl/sig_lut_if.sv | 28 ++
 rtl/sig_lut_loader.sv | 103 ++++++++++
 tb/tb_sig_lut_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sig_lut_if.sv
// Load and lookup signals of the activation lookup-table loader.
// The master side streams table entries and issues lookups; the slave side is the table.
interface sig_lut_if #(
  parameter int inWidth   = 10,
  parameter int dataWidth = 16
) ();
  logic                 load_start;
  logic                 load_valid;
  logic [dataWidth-1:0] load_data;
  logic                 load_ready;
  logic                 load_done;
  logic                 table_ready;
  logic [inWidth-1:0]   x;
  logic                 x_valid;
  logic [dataWidth-1:0] out;
  logic                 out_valid;
  logic                 lookup_err;

  modport master (
    output load_start, load_valid, load_data, x, x_valid,
    input  load_ready, load_done, table_ready, out, out_valid, lookup_err
  );

  modport slave (
    input  load_start, load_valid, load_data, x, x_valid,
    output load_ready, load_done, table_ready, out, out_valid, lookup_err
  );
endinterface

// File: rtl/sig_lut_loader.sv
// Activation lookup table: streamed in-order load into a synchronous RAM, then
// pipelined signed lookups with two cycles of latency.
//
// state  | meaning
// IDLE   | no valid table; waiting for load_start
// LOAD   | accepting entries in address order
// ACTIVE | table complete; lookups serviced
module sig_lut_loader #(
  parameter int inWidth   = 10,
  parameter int dataWidth = 16
) (
  input logic   clk,
  input logic   rst_n,
  sig_lut_if.slave bus
);
  localparam int Depth = 2 ** inWidth;
  localparam logic [inWidth:0] LastIdx = (inWidth + 1)'(Depth - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  state_t               state_q, state_d;
  logic [inWidth:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 xfer;
  logic                 lookup;
  logic [dataWidth-1:0] ram [Depth];
  logic [inWidth-1:0]   addr_q;
  logic                 addr_v_q;
  logic [dataWidth-1:0] out_q;
  logic                 out_v_q;
  logic                 err_q;

  // A load_start in LOAD restarts the load, so a beat presented alongside it is dropped.
  assign xfer   = (state_q == LOAD) && bus.load_valid && !bus.load_start;
  assign lookup = (state_q == ACTIVE) && bus.x_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (bus.load_start) begin
          cnt_d = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + (inWidth + 1)'(1);
          if (cnt_q == LastIdx) begin
            state_d = ACTIVE;
            done_d  = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      addr_v_q <= 1'b0;
      out_q    <= '0;
      out_v_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      addr_v_q <= lookup;
      // Flipping the sign bit turns the two's-complement argument into an offset-binary address.
      if (lookup) addr_q <= {~bus.x[inWidth-1], bus.x[inWidth-2:0]};
      out_v_q  <= addr_v_q;
      if (addr_v_q) out_q <= ram[addr_q];
      err_q    <= bus.x_valid && (state_q != ACTIVE);
    end
  end

  // Table contents survive reset; only a completed reload makes them valid again.
  always_ff @(posedge clk) begin
    if (xfer) ram[cnt_q[inWidth-1:0]] <= bus.load_data;
  end

  assign bus.load_ready  = (state_q == LOAD);
  assign bus.table_ready = (state_q == ACTIVE);
  assign bus.load_done   = done_q;
  assign bus.out         = out_q;
  assign bus.out_valid   = out_v_q;
  assign bus.lookup_err  = err_q;
endmodule

// File: tb/tb_sig_lut_loader.sv
// Scoreboard bench for sig_lut_loader: lookups push expected values, a negedge
// monitor pops and compares whenever out_valid is presented.
module tb_sig_lut_loader;
  localparam int IW = 10;
  localparam int DW = 16;
  localparam int N  = 1 << IW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sig_lut_if #(.inWidth(IW), .dataWidth(DW)) bus ();

  sig_lut_loader #(.inWidth(IW), .dataWidth(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented output must match the oldest outstanding lookup.
  always @(negedge clk) begin
    if (rst_n && bus.load_done) done_cnt++;
    if (rst_n && bus.out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got %0h with no lookup outstanding at %0t", bus.out, $time);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.out !== e) begin
          errors++;
          $display("FAIL lookup_out: got %0h expected %0h at %0t", bus.out, e, $time);
        end
      end
    end
  end

  function automatic logic [DW-1:0] pat(input int i, input int mode);
    case (mode)
      0:       return DW'(i);
      1:       return ~DW'(i);
      default: return DW'(i * 37 + 5);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"},  32'(bus.load_ready),  32'd0);
    check({tag, "_load_done"},   32'(bus.load_done),   32'd0);
    check({tag, "_table_ready"}, 32'(bus.table_ready), 32'd0);
    check({tag, "_out_valid"},   32'(bus.out_valid),   32'd0);
    check({tag, "_lookup_err"},  32'(bus.lookup_err),  32'd0);
    check({tag, "_out"},         32'(bus.out),         32'd0);
  endtask

  // Lookup while not ACTIVE: error one cycle later, never an output.
  task automatic early_lookup(input string tag);
    bus.x = 10'd5;
    bus.x_valid = 1'b1;
    tick();
    bus.x_valid = 1'b0;
    @(negedge clk);
    check({tag, "_err_pulse"}, 32'(bus.lookup_err), 32'd1);
    check({tag, "_no_out"},    32'(bus.out_valid),  32'd0);
    tick();
    @(negedge clk);
    check({tag, "_err_clear"}, 32'(bus.lookup_err), 32'd0);
    check({tag, "_no_out2"},   32'(bus.out_valid),  32'd0);
    tick();
  endtask

  task automatic do_load(input int n_beats, input int mode, input bit gapped, input bit expect_done);
    int sent;
    int budget;
    bit v;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    sent = 0;
    budget = 0;
    while (sent < n_beats) begin
      v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.load_valid = v;
      bus.load_data  = pat(sent, mode);
      if (sent == 0 && budget == 0) begin
        @(negedge clk);
        check("load_ready", 32'(bus.load_ready), 32'd1);
      end
      tick();
      if (v) begin
        mem[sent] = pat(sent, mode);
        sent++;
      end
      budget++;
      if (budget > 8 * N) begin
        check("load_budget", 32'(sent), 32'(n_beats));
        break;
      end
    end
    bus.load_valid = 1'b0;
    if (expect_done) begin
      @(negedge clk);
      check("load_done_pulse", 32'(bus.load_done),   32'd1);
      check("table_ready_set", 32'(bus.table_ready), 32'd1);
      tick();
      @(negedge clk);
      check("load_done_single", 32'(bus.load_done), 32'd0);
      tick();
    end
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic readback_all(input string tag);
    logic [IW-1:0] a;
    for (int i = 0; i < N; i++) begin
      a = IW'(i);
      bus.x = {~a[IW-1], a[IW-2:0]};
      bus.x_valid = 1'b1;
      exp_q.push_back(mem[i]);
      tick();
    end
    bus.x_valid = 1'b0;
    drain(tag);
  endtask

  initial begin
    int d0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.x          = '0;
    bus.x_valid    = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    early_lookup("idle_lookup");

    // Full load with data = index
    d0 = done_cnt;
    do_load(N, 0, 1'b0, 1'b1);
    check("full_load_done_count", 32'(done_cnt - d0), 32'd1);

    // Mapping: -512, 0, +511 give 0, 512, 1023 on N+2..N+4
    bus.x = 10'h200; bus.x_valid = 1'b1; exp_q.push_back(16'd0);
    @(negedge clk);
    check("map_lat_n", 32'(bus.out_valid), 32'd0);
    tick();
    bus.x = 10'h000; exp_q.push_back(16'd512);
    @(negedge clk);
    check("map_lat_n1", 32'(bus.out_valid), 32'd0);
    tick();
    bus.x = 10'h1FF; exp_q.push_back(16'd1023);
    @(negedge clk);
    check("map_lat_n2", 32'(bus.out_valid), 32'd1);
    tick();
    bus.x_valid = 1'b0;
    drain("map");

    // Reload requested together with a lookup: old contents are read
    bus.load_start = 1'b1;
    bus.x = 10'd5; bus.x_valid = 1'b1; exp_q.push_back(16'd517);
    tick();
    bus.load_start = 1'b0;
    bus.x = 10'd6;
    @(negedge clk);
    check("reload_table_drop", 32'(bus.table_ready), 32'd0);
    tick();
    bus.x_valid = 1'b0;
    @(negedge clk);
    check("reload_lookup_err", 32'(bus.lookup_err), 32'd1);
    check("reload_out_valid",  32'(bus.out_valid),  32'd1);
    drain("reload");

    // Gapped load, then full readback
    do_load(N, 2, 1'b1, 1'b1);
    readback_all("gapped");

    // Abort after 300 entries, reload with ~index
    d0 = done_cnt;
    do_load(300, 0, 1'b0, 1'b0);
    do_load(N, 1, 1'b0, 1'b1);
    check("abort_done_count", 32'(done_cnt - d0), 32'd1);
    readback_all("abort");

    // Reset in the middle of a load
    d0 = done_cnt;
    do_load(100, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midload_no_done", 32'(done_cnt - d0), 32'd0);
    early_lookup("post_reset_lookup");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
